rr_decoder_arbiter: RTL and testbench

//  Round-robin arbiter sharing one resource among 4 requesters. The winner is

---
 rtl/rr_decoder_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_decoder_arbiter
// Description : 4-way round-robin arbiter with a per-owner hold quantum. The
//               winner is kept as a registered 2-bit index plus enable, and
//               the grant vector is its gated 2-to-4 decode.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_decoder_arbiter #(
    parameter int QUANTUM = 8,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_GRANT   = 1'b1;
    localparam logic [CNT_W-1:0] c_quantum = CNT_W'(QUANTUM);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    logic [0:0]       r_state;
    logic [1:0]       r_gnt_idx;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;

    logic [0:0]       w_state_nxt;
    logic [1:0]       w_gnt_idx_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;

    logic [3:0]       w_others;
    logic [1:0]       w_win_all;
    logic [1:0]       w_win_oth;
    logic             w_owner_req;

    // First index with its bit set, scanning upward from p+1 and wrapping,
    // so p itself is examined last.
    function automatic logic [1:0] f_pick(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] w_sel;
        logic       w_found;
        logic [1:0] w_cand;
        w_sel   = p;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = p + 2'(k);
            if (!w_found && v[w_cand]) begin
                w_sel   = w_cand;
                w_found = 1'b1;
            end
        end
        return w_sel;
    endfunction

    always_comb begin
        w_others            = req;
        w_others[r_gnt_idx] = 1'b0;
    end

    assign w_owner_req = req[r_gnt_idx];
    assign w_win_all   = f_pick(req, r_ptr);
    assign w_win_oth   = f_pick(w_others, r_ptr);

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_idx_nxt  = r_gnt_idx;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (req != 4'b0000) begin
                    w_state_nxt    = S_GRANT;
                    w_gnt_idx_nxt  = w_win_all;
                    w_ptr_nxt      = w_win_all;
                    w_hold_cnt_nxt = c_one;
                end
            end
            S_GRANT: begin
                if (!w_owner_req) begin
                    if (w_others != 4'b0000) begin
                        w_gnt_idx_nxt  = w_win_oth;
                        w_ptr_nxt      = w_win_oth;
                        w_hold_cnt_nxt = c_one;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if ((r_hold_cnt >= c_quantum) && (w_others != 4'b0000)) begin
                    w_gnt_idx_nxt  = w_win_oth;
                    w_ptr_nxt      = w_win_oth;
                    w_hold_cnt_nxt = c_one;
                end else if (r_hold_cnt < c_quantum) begin
                    // Saturate at the quantum rather than wrapping.
                    w_hold_cnt_nxt = r_hold_cnt + c_one;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt_idx  <= 2'd0;
            r_ptr      <= 2'd3;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    assign gnt_valid = (r_state == S_GRANT);
    assign gnt_idx   = r_gnt_idx;

    for (genvar i = 0; i < 4; i++) begin : g_dec
        assign gnt[i] = gnt_valid && (r_gnt_idx == 2'(i));
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_decoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_decoder_arbiter
// Description : Directed bench for rr_decoder_arbiter (QUANTUM=8 and QUANTUM=2
//               instances) against an in-bench reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       vld_a, vld_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_decoder_arbiter #(.QUANTUM(8), .CNT_W(4)) u_dut_q8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a)
    );

    rr_decoder_arbiter #(.QUANTUM(2), .CNT_W(2)) u_dut_q2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b)
    );

    // Reference model: owner, rotation pointer and an unbounded count of
    // consecutive cycles the owner has held the resource.
    int m_quantum [2] = '{8, 2};
    bit m_valid   [2];
    int m_owner   [2];
    int m_ptr     [2];
    int m_held    [2];

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [3:0] oth;
            if (!rst_n) begin
                m_valid[i] = 1'b0; m_owner[i] = 0; m_ptr[i] = 3; m_held[i] = 0;
            end else if (!m_valid[i]) begin
                if (req != 4'b0) begin
                    m_owner[i] = pick(req, m_ptr[i]); m_ptr[i] = m_owner[i];
                    m_valid[i] = 1'b1; m_held[i] = 1;
                end
            end else begin
                oth = req;
                oth[m_owner[i]] = 1'b0;
                if (!req[m_owner[i]] || (m_held[i] >= m_quantum[i] && oth != 4'b0)) begin
                    if (oth != 4'b0) begin
                        m_owner[i] = pick(oth, m_ptr[i]); m_ptr[i] = m_owner[i];
                        m_held[i] = 1;
                    end else begin
                        m_valid[i] = 1'b0;
                    end
                end else begin
                    m_held[i] = m_held[i] + 1;
                end
            end
        end
    end

    function automatic logic [3:0] model_gnt(input int i);
        return m_valid[i] ? (4'b0001 << m_owner[i]) : 4'b0000;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n !== 1'bx) begin
            total++;
            if (gnt_a !== model_gnt(0) || vld_a !== m_valid[0] || idx_a !== 2'(m_owner[0])) begin
                bad++;
                $display("FAIL model_q8 t=%0t gnt=%b vld=%b idx=%0d required gnt=%b vld=%b idx=%0d",
                         $time, gnt_a, vld_a, idx_a, model_gnt(0), m_valid[0], m_owner[0]);
            end
            total++;
            if (gnt_b !== model_gnt(1) || vld_b !== m_valid[1] || idx_b !== 2'(m_owner[1])) begin
                bad++;
                $display("FAIL model_q2 t=%0t gnt=%b vld=%b idx=%0d required gnt=%b vld=%b idx=%0d",
                         $time, gnt_b, vld_b, idx_b, model_gnt(1), m_valid[1], m_owner[1]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic [3:0] rot_exp [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                4'b0100, 4'b1000, 4'b1000, 4'b0001};

    initial begin
        rst_n = 1'bx;
        req   = 4'b0000;
        @(negedge clk);

        // Reset held with all requests active
        rst_n = 1'b0; req = 4'b1111;
        tick(); tick();
        chk("reset_gnt", 8'(gnt_a), 8'h00);
        chk("reset_vld", 8'(vld_a), 8'h00);
        chk("reset_idx", 8'(idx_a), 8'h00);
        rst_n = 1'b1;
        tick();
        chk("post_reset_gnt", 8'(gnt_a), 8'h01);

        // Single requester, then release to idle
        req = 4'b0100;
        tick();
        chk("single_gnt", 8'(gnt_a), 8'h04);
        chk("single_idx", 8'(idx_a), 8'h02);
        tick();
        chk("single_hold", 8'(gnt_a), 8'h04);
        req = 4'b0000;
        tick();
        chk("release_gnt", 8'(gnt_a), 8'h00);
        chk("release_vld", 8'(vld_a), 8'h00);

        // Rotation with QUANTUM=2
        rst_n = 1'b0; tick();
        rst_n = 1'b1; req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("rot_q2_%0d", k), 8'(gnt_b), 8'(rot_exp[k]));
        end

        // Handoff without idle gap
        rst_n = 1'b0; req = 4'b0000; tick();
        rst_n = 1'b1; req = 4'b0001; tick();
        chk("handoff_pre", 8'(gnt_a), 8'h01);
        req = 4'b1000; tick();
        chk("handoff_gnt", 8'(gnt_a), 8'h08);
        chk("handoff_vld", 8'(vld_a), 8'h01);

        // Lone requester holds past the quantum; contender then preempts
        rst_n = 1'b0; req = 4'b0000; tick();
        rst_n = 1'b1; req = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("lone_%0d", k), 8'(gnt_a), 8'h02);
        end
        req = 4'b0011; tick();
        chk("preempt_q8", 8'(gnt_a), 8'h01);

        // Reset in the middle of a grant
        rst_n = 1'b0; req = 4'b0000; tick();
        rst_n = 1'b1; req = 4'b0100; tick();
        chk("mid_pre", 8'(gnt_a), 8'h04);
        rst_n = 1'b0; req = 4'b0110; tick();
        chk("mid_reset_gnt", 8'(gnt_a), 8'h00);
        rst_n = 1'b1; tick();
        chk("mid_after_gnt", 8'(gnt_a), 8'h02);

        req = 4'b0000; tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
